// File: rtl/captura_jogada.sv
// captura_jogada: answer-button capture stage in front of the game control unit.
// Synchronizes and debounces the player buttons, emits a one-cycle jogada_feita pulse with
// the registered one-hot answer, and runs the answer-window timer that raises timeout.
module captura_jogada #(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic                jogada_feita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                timeout,
  output logic [2:0]          db_estado
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StOcioso   = 3'd0,
    StSoltar   = 3'd1,
    StArmado   = 3'd2,
    StFiltra   = 3'd3,
    StAceito   = 3'd4,
    StEsgotado = 3'd5
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] sync1_q, b_q;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                pulso_q;
  logic                aceita;
  logic                b_onehot;
  logic                timer_fim;

  // Two-flop synchronizer for the raw asynchronous buttons.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= '0;
      b_q     <= '0;
    end else begin
      sync1_q <= botoes;
      b_q     <= sync1_q;
    end
  end

  // Next-state logic: habilita low aborts from anywhere; debounce completion beats the timer.
  always_comb begin
    estado_d  = estado_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    aceita    = 1'b0;
    b_onehot  = (b_q != '0) && ((b_q & (b_q - N_BOTOES'(1))) == '0);
    timer_fim = (timer_q == TMAX);
    if (!habilita) begin
      estado_d = StOcioso;
    end else begin
      unique case (estado_q)
        StOcioso: estado_d = (b_q != '0) ? StSoltar : StArmado;
        // A button still held from the previous round must be released first.
        StSoltar: begin
          if (b_q == '0) estado_d = StArmado;
        end
        StArmado: begin
          if (timer_fim) begin
            estado_d = StEsgotado;
          end else if (b_onehot) begin
            cand_d   = b_q;
            cnt_d    = '0;
            estado_d = StFiltra;
          end
        end
        StFiltra: begin
          if ((b_q == cand_q) && (cnt_q == CMAX)) begin
            estado_d = StAceito;
            aceita   = 1'b1;
          end else if (timer_fim) begin
            estado_d = StEsgotado;
          end else if (b_q != cand_q) begin
            estado_d = StArmado;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StAceito:   estado_d = StAceito;
        StEsgotado: estado_d = StEsgotado;
        default:    estado_d = StOcioso;
      endcase
    end
  end

  // State, candidate and debounce counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= StOcioso;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  // Answer-window timer: cleared while idle, runs only while armed or filtering, saturates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (estado_q == StOcioso) begin
      timer_q <= '0;
    end else if (((estado_q == StArmado) || (estado_q == StFiltra)) && !timer_fim) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Registered answer and acceptance pulse; jogada survives aborts and timeouts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      jogada_q <= '0;
      pulso_q  <= 1'b0;
    end else begin
      pulso_q <= aceita;
      if (aceita) jogada_q <= cand_q;
    end
  end

  assign jogada_feita = pulso_q;
  assign jogada       = jogada_q;
  assign timeout      = (estado_q == StEsgotado);
  assign db_estado    = estado_q;

endmodule
